// File: rtl/rst_seq_bank.sv
// Multi-channel reset distributor. Reset assertion is asynchronous. Release is synchronised, held for a fixed time, then staggered by channel index.
// Optional RST_SEQ_SOFT_COUNT_EN adds a saturating soft_count output.
module rst_seq_bank #(
    parameter int NCH         = 20,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGGER     = 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           soft_req,
    input  logic [NCH-1:0] chan_mask,
    output logic [NCH-1:0] rstn_out,
    output logic           all_released,
    output logic           busy,
`ifdef RST_SEQ_SOFT_COUNT_EN
    output logic [7:0]     soft_count,
`endif
    output logic           soft_ack
);
    localparam int CMAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(NCH + 1);

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic                   soft_pend;
    logic                   last_slot;

    // Edge that releases the final channel; RUN is entered on this same edge.
    always_comb begin
        last_slot = 1'b0;
        if (state == ST_HOLD && cnt == CW'(HOLD_CYCLES - 1) && NCH == 1)
            last_slot = 1'b1;
        if (state == ST_REL && cnt == CW'(STAGGER - 1) && idx == IW'(NCH - 1))
            last_slot = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_SYNC;
            sync_q       <= '0;
            cnt          <= '0;
            idx          <= '0;
            soft_pend    <= 1'b0;
            rstn_out     <= '0;
            all_released <= 1'b0;
            busy         <= 1'b1;
            soft_ack     <= 1'b0;
        end else begin
            soft_ack <= 1'b0;
            case (state)
                ST_SYNC: begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
                    if (sync_q[SYNC_STAGES-2]) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        cnt         <= '0;
                        idx         <= IW'(1);
                        rstn_out[0] <= ~chan_mask[0];
                        state       <= ST_REL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_REL: begin
                    if (cnt == CW'(STAGGER - 1)) begin
                        cnt <= '0;
                        idx <= idx + 1'b1;
                        // A masked channel still consumes its slot so timing is mask-independent.
                        for (int k = 0; k < NCH; k++)
                            if (idx == IW'(k)) rstn_out[k] <= ~chan_mask[k];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (soft_req) begin
                        rstn_out     <= '0;
                        all_released <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ST_HOLD;
                        cnt          <= '0;
                        soft_pend    <= 1'b1;
                    end else begin
                        // Newly masked channels drop; unmasked ones wait for the next release.
                        rstn_out <= rstn_out & ~chan_mask;
                    end
                end
            endcase
            if (last_slot) begin
                state        <= ST_RUN;
                all_released <= 1'b1;
                busy         <= 1'b0;
                soft_ack     <= soft_pend;
                soft_pend    <= 1'b0;
            end
        end
    end

`ifdef RST_SEQ_SOFT_COUNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            soft_count <= 8'd0;
        else if (last_slot && soft_pend && soft_count != 8'hFF)
            soft_count <= soft_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_rst_seq_bank.sv
// Scoreboard bench for rst_seq_bank (NCH=4, SYNC_STAGES=2, HOLD_CYCLES=4, STAGGER=3).
module tb_rst_seq_bank;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       soft_req = 1'b0;
    logic [3:0] chan_mask = 4'b0000;
    logic [3:0] rstn_out;
    logic       all_released, busy, soft_ack;
`ifdef RST_SEQ_SOFT_COUNT_EN
    logic [7:0] soft_count;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int         c;
        logic [6:0] v;
        string      nm;
    } exp_t;
    exp_t q[$];

    rst_seq_bank #(.NCH(4), .SYNC_STAGES(2), .HOLD_CYCLES(4), .STAGGER(3)) dut (
        .clk(clk), .rstn(rstn), .soft_req(soft_req), .chan_mask(chan_mask),
        .rstn_out(rstn_out), .all_released(all_released), .busy(busy),
`ifdef RST_SEQ_SOFT_COUNT_EN
        .soft_count(soft_count),
`endif
        .soft_ack(soft_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] v(logic [3:0] r, logic ar, logic b, logic a);
        return {r, ar, b, a};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_at(int c, logic [6:0] val, string nm);
        exp_t e;
        e.c = c; e.v = val; e.nm = nm;
        q.push_back(e);
    endtask

    // Monitor: compares DUT outputs against queued expectations on the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.c < cyc) begin
                checks++; failures++;
                $display("FAIL %s: expectation for cyc %0d missed", e.nm, e.c);
            end else begin
                chk(e.nm, 32'({rstn_out, all_released, busy, soft_ack}), 32'(e.v));
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) @(posedge clk);
        #1;
    endtask

    // Standard power-on with no mask: bits at 6/9/12/15, RUN at 15.
    task automatic po_exp_std(int b, string nm);
        expect_at(b + 5,  v(4'b0000, 0, 1, 0), {nm, "_e5"});
        expect_at(b + 6,  v(4'b0001, 0, 1, 0), {nm, "_e6"});
        expect_at(b + 8,  v(4'b0001, 0, 1, 0), {nm, "_e8"});
        expect_at(b + 9,  v(4'b0011, 0, 1, 0), {nm, "_e9"});
        expect_at(b + 11, v(4'b0011, 0, 1, 0), {nm, "_e11"});
        expect_at(b + 12, v(4'b0111, 0, 1, 0), {nm, "_e12"});
        expect_at(b + 14, v(4'b0111, 0, 1, 0), {nm, "_e14"});
        expect_at(b + 15, v(4'b1111, 1, 0, 0), {nm, "_e15"});
        expect_at(b + 16, v(4'b1111, 1, 0, 0), {nm, "_e16"});
    endtask

    task automatic soft_exp_std(int t, string nm);
        expect_at(t,      v(4'b0000, 0, 1, 0), {nm, "_t0"});
        expect_at(t + 3,  v(4'b0000, 0, 1, 0), {nm, "_t3"});
        expect_at(t + 4,  v(4'b0001, 0, 1, 0), {nm, "_t4"});
        expect_at(t + 7,  v(4'b0011, 0, 1, 0), {nm, "_t7"});
        expect_at(t + 10, v(4'b0111, 0, 1, 0), {nm, "_t10"});
        expect_at(t + 12, v(4'b0111, 0, 1, 0), {nm, "_t12"});
        expect_at(t + 13, v(4'b1111, 1, 0, 1), {nm, "_t13"});
    endtask

    initial begin
        int b, t, e;
        tick(2);
        expect_at(cyc + 1, v(4'b0000, 0, 1, 0), "reset_state");
        tick(2);

        // 1. power-on
        rstn = 1'b1; b = cyc;
        po_exp_std(b, "po");
        wait_cyc(b + 16);

        // 2. mid-sequence reset at edge 10
        rstn = 1'b0; tick(2);
        rstn = 1'b1; b = cyc;
        expect_at(b + 10, v(4'b0011, 0, 1, 0), "mid_e10");
        wait_cyc(b + 10);
        rstn = 1'b0; #1;
        chk("async_assert", 32'({rstn_out, all_released, busy, soft_ack}), 32'(v(4'b0000, 0, 1, 0)));
        expect_at(cyc + 1, v(4'b0000, 0, 1, 0), "held_reset");
        tick(2);
        rstn = 1'b1; b = cyc;
        po_exp_std(b, "po2");
        wait_cyc(b + 16);

        // 3. soft reset with request held a few cycles
        soft_req = 1'b1; t = cyc + 1;
        soft_exp_std(t, "soft");
        expect_at(t + 14, v(4'b1111, 1, 0, 0), "soft_ack_1cyc");
        tick(5); soft_req = 1'b0;
        wait_cyc(t + 14);

        // 3b. request still high after ack restarts immediately
        soft_req = 1'b1; t = cyc + 1;
        expect_at(t,      v(4'b0000, 0, 1, 0), "rt_t0");
        expect_at(t + 13, v(4'b1111, 1, 0, 1), "rt_t13");
        expect_at(t + 14, v(4'b0000, 0, 1, 0), "rt_restart");
        expect_at(t + 27, v(4'b1111, 1, 0, 1), "rt_t27");
        expect_at(t + 28, v(4'b1111, 1, 0, 0), "rt_t28");
        wait_cyc(t + 14); soft_req = 1'b0;
        wait_cyc(t + 28);

        // 4. masking during power-on and in RUN
        rstn = 1'b0; tick(2);
        chan_mask = 4'b0100; rstn = 1'b1; b = cyc;
        expect_at(b + 6,  v(4'b0001, 0, 1, 0), "mask_e6");
        expect_at(b + 9,  v(4'b0011, 0, 1, 0), "mask_e9");
        expect_at(b + 12, v(4'b0011, 0, 1, 0), "mask_e12");
        expect_at(b + 14, v(4'b0011, 0, 1, 0), "mask_e14");
        expect_at(b + 15, v(4'b1011, 1, 0, 0), "mask_e15");
        wait_cyc(b + 16);
        chan_mask = 4'b0101; e = cyc + 1;
        expect_at(e, v(4'b1010, 1, 0, 0), "mask_rise");
        tick(1);
        chan_mask = 4'b0000;
        expect_at(e + 1, v(4'b1010, 1, 0, 0), "mask_fall_e1");
        expect_at(e + 3, v(4'b1010, 1, 0, 0), "mask_fall_e3");
        wait_cyc(e + 3);
        soft_req = 1'b1; t = cyc + 1;
        soft_exp_std(t, "mask_soft");
        tick(1); soft_req = 1'b0;
        wait_cyc(t + 14);

        // 5. soft request and mask rise on the same edge
        soft_req = 1'b1; chan_mask = 4'b0001; t = cyc + 1;
        soft_exp_std(t, "simul");
        tick(1); soft_req = 1'b0; chan_mask = 4'b0000;
        wait_cyc(t + 14);

        // 5b. soft request while busy after power-on is ignored
        rstn = 1'b0; tick(2);
        soft_req = 1'b1; rstn = 1'b1; b = cyc;
        po_exp_std(b, "busy_soft");
        wait_cyc(b + 14); soft_req = 1'b0;
        wait_cyc(b + 16);

`ifdef RST_SEQ_SOFT_COUNT_EN
        // 6. soft reset counter
        rstn = 1'b0; #1;
        chk("cnt_reset", 32'(soft_count), 32'd0);
        tick(2);
        rstn = 1'b1; b = cyc;
        wait_cyc(b + 16);
        for (int n = 1; n <= 3; n++) begin
            soft_req = 1'b1; t = cyc + 1;
            tick(1); soft_req = 1'b0;
            wait_cyc(t + 14);
            chk($sformatf("cnt_%0d", n), 32'(soft_count), 32'(n));
        end
        rstn = 1'b0; #1;
        chk("cnt_async_clr", 32'(soft_count), 32'd0);
        tick(2);
        rstn = 1'b1; b = cyc;
        wait_cyc(b + 16);
        for (int n = 1; n <= 260; n++) begin
            soft_req = 1'b1; t = cyc + 1;
            tick(1); soft_req = 1'b0;
            wait_cyc(t + 14);
        end
        chk("cnt_saturate", 32'(soft_count), 32'd255);
`endif

        for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
